// File: rtl/mcpu_program_loader_pkg.sv
// Shared definitions for the MCPU program loader: machine sizes, loader state
// encoding and header decoding.
package mcpu_program_loader_pkg;

  localparam int MCPU_WORD_SIZE    = 16;
  localparam int MCPU_OPCODE_SIZE  = 4;
  localparam int MCPU_OPERAND_SIZE = 4;
  localparam int MCPU_ADDR_SIZE    = 8;
  localparam int MCPU_RAM_SIZE     = 256;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_HDR,
    S_HI,
    S_LO,
    S_WR,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_t;

  // A header byte of zero stands for a full 256-word program.
  function automatic logic [8:0] word_count(input logic [7:0] hdr);
    return (hdr == 8'h00) ? 9'd256 : {1'b0, hdr};
  endfunction

endpackage

// File: rtl/mcpu_program_loader.sv
// Streams a header/instruction/checksum byte sequence into MCPU RAM, clearing
// RAM first and holding the CPU in reset until a verified load completes.
module mcpu_program_loader
  import mcpu_program_loader_pkg::*;
#(
  parameter int WORD_SIZE = MCPU_WORD_SIZE,
  parameter int ADDR_SIZE = MCPU_ADDR_SIZE,
  parameter int RAM_SIZE  = MCPU_RAM_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_byte,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error
);

  loader_state_t state;
  logic [7:0]    csum;
  logic [8:0]    remaining;
  logic          xfer;

  assign xfer = in_valid & in_ready;

  // Every output is assigned alongside the state so it reflects the state it
  // is entering; mem_we defaults low and is raised only for CLEAR and WR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      csum      <= 8'h00;
      remaining <= 9'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_CLEAR;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b1;
            csum      <= 8'h00;
            in_ready  <= 1'b0;
          end
        end

        S_CLEAR: begin
          if (mem_addr == ADDR_SIZE'(RAM_SIZE - 1)) begin
            state    <= S_HDR;
            mem_addr <= '0;
            in_ready <= 1'b1;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            mem_we   <= 1'b1;
          end
        end

        S_HDR: begin
          if (xfer) begin
            remaining <= word_count(in_byte);
            state     <= S_HI;
          end
        end

        S_HI: begin
          if (xfer) begin
            mem_wdata[WORD_SIZE-1 -: 8] <= in_byte;
            csum                        <= csum ^ in_byte;
            state                       <= S_LO;
          end
        end

        S_LO: begin
          if (xfer) begin
            mem_wdata[7:0] <= in_byte;
            csum           <= csum ^ in_byte;
            state          <= S_WR;
            in_ready       <= 1'b0;
            mem_we         <= 1'b1;
          end
        end

        S_WR: begin
          mem_addr  <= mem_addr + 1'b1;
          remaining <= remaining - 9'd1;
          in_ready  <= 1'b1;
          state     <= (remaining == 9'd1) ? S_CSUM : S_HI;
        end

        S_CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_byte == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
